// File: rtl/mathbox_pkg.sv
// Shared definitions for the mathbox microprogram sequencer: microword field
// positions, sequencer states and the dispatch table base address.
package mathbox_pkg;

    localparam int MW_BA_HI = 23;
    localparam int MW_BA_LO = 16;
    localparam int MW_JMP   = 7;
    localparam int MW_STOP  = 4;
    localparam int MW_COND  = 2;

    // Dispatch entries live at the bottom of the microcode ROM.
    localparam logic [7:0] DISPATCH_BASE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } seq_state_t;

    // Map a CPU write register index onto its dispatch entry address.
    function automatic logic [7:0] dispatchAddr(input logic [4:0] idx);
        return DISPATCH_BASE | {3'b000, idx};
    endfunction

endpackage

// File: rtl/mathbox_next_addr.sv
// Combinational next-address selection for the microprogram sequencer.
// A taken jump loads the branch address, anything else steps to pc+1 with
// natural 8-bit wrap. STOP handling is left to the caller.
module mathbox_next_addr
    import mathbox_pkg::*;
(
    input  logic [7:0] pc_i,
    input  logic [7:0] ba_i,
    input  logic       jmp_i,
    input  logic       cond_i,
    input  logic       aluCond_i,
    output logic [7:0] next_o
);

    // Unconditional jumps always take, conditional jumps follow the ALU flag.
    always_comb begin
        next_o = pc_i + 8'd1;
        if (jmp_i && (!cond_i || aluCond_i)) begin
            next_o = ba_i;
        end
    end

endmodule

// File: rtl/mathbox_sequencer.sv
// Microprogram sequencer: drives the microcode ROM address, issues each
// returned word to the ALU, resolves jumps and stops on the STOP bit.
// A runaway program is aborted after MAX_STEPS executed words.
module mathbox_sequencer
    import mathbox_pkg::*;
#(
    parameter int MAX_STEPS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic [4:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        busy,
    output logic        overrun,
    output logic        timeout,
    output logic        done,
    output logic [7:0]  rom_addr,
    output logic        rom_cs,
    input  logic [23:0] rom_dout,
    input  logic        alu_cond,
    output logic        uop_valid,
    output logic [23:0] uop,
    output logic [7:0]  uop_data
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

    seq_state_t        state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        nextAddr;

    mathbox_next_addr u_next_addr (
        .pc_i      (pc_q),
        .ba_i      (rom_dout[MW_BA_HI:MW_BA_LO]),
        .jmp_i     (rom_dout[MW_JMP]),
        .cond_i    (rom_dout[MW_COND]),
        .aluCond_i (alu_cond),
        .next_o    (nextAddr)
    );

    // State and program registers; reset abandons any running program silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= 8'h00;
            step_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
        end
    end

    // Sequencing: dispatch from IDLE, re-issue the start address in FETCH so the
    // ROM word lines up with EXEC, then stream one word per cycle in EXEC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        step_d    = step_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        data_d    = data_q;
        rom_addr  = pc_q;
        rom_cs    = 1'b0;
        uop_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_wr) begin
                    rom_addr  = dispatchAddr(cpu_addr);
                    rom_cs    = 1'b1;
                    pc_d      = dispatchAddr(cpu_addr);
                    step_d    = '0;
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                    data_d    = cpu_data;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                rom_cs  = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                if (step_q == STEP_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    uop_valid = 1'b1;
                    step_d    = step_q + STEP_W'(1);
                    if (rom_dout[MW_STOP]) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rom_addr = nextAddr;
                        rom_cs   = 1'b1;
                        pc_d     = nextAddr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cpu_wr && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;
    assign uop      = rom_dout;
    assign uop_data = data_q;

endmodule

// File: tb/tb_mathbox_sequencer.sv
// Self-checking bench for mathbox_sequencer with a behavioural 1-cycle ROM.
// Expected microword streams are computed from the ROM image when a program
// is dispatched and consumed as the sequencer issues words.
module tb_mathbox_sequencer;

    localparam int MAX_STEPS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_wr;
    logic [4:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        busy, overrun, timeout, done;
    logic [7:0]  rom_addr;
    logic        rom_cs;
    logic [23:0] romDout;
    logic        alu_cond;
    logic        uop_valid;
    logic [23:0] uop;
    logic [7:0]  uop_data;

    logic [23:0] rom [256];

    typedef struct {
        logic [23:0] word;
        logic [7:0]  nextAddr;
        logic        stop;
        logic [7:0]  data;
    } expEntry_t;

    expEntry_t expQ[$];
    expEntry_t monEntry;
    logic      expTimeout;
    logic      monEn = 1'b0;
    int        checkCount = 0;
    int        errorCount = 0;
    int        validCount = 0;
    int        doneCount  = 0;

    mathbox_sequencer #(.MAX_STEPS(MAX_STEPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .busy      (busy),
        .overrun   (overrun),
        .timeout   (timeout),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_dout  (romDout),
        .alu_cond  (alu_cond),
        .uop_valid (uop_valid),
        .uop       (uop),
        .uop_data  (uop_data)
    );

    always #5 clk = ~clk;

    // Registered microcode ROM: address in one cycle, word out the next.
    always @(posedge clk) begin
        if (rom_cs) romDout <= rom[rom_addr];
    end

    // The ALU condition for the issued word is carried in its bit 0.
    assign alu_cond = romDout[0];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [23:0] mkWord(input logic [7:0] ba, input logic jmp, input logic cond,
                                           input logic stop, input logic condBit);
        return {ba, 8'h5A, jmp, 2'b00, stop, 1'b0, cond, 1'b0, condBit};
    endfunction

    // Walk the ROM image the way the sequencer should and queue each word.
    task automatic pushExpected(input logic [7:0] start, input logic [7:0] data);
        logic [7:0]  pc = start;
        logic [23:0] w;
        logic        take;
        expEntry_t   e;
        int          steps = 0;
        expTimeout = 1'b1;
        while (steps < MAX_STEPS) begin
            w = rom[pc];
            take = w[7] && (!w[2] || w[0]);
            e.word = w;
            e.nextAddr = take ? w[23:16] : pc + 8'd1;
            e.stop = w[4];
            e.data = data;
            expQ.push_back(e);
            steps++;
            if (w[4]) begin
                expTimeout = 1'b0;
                break;
            end
            pc = e.nextAddr;
        end
    endtask

    // Issue an accepted write and check the dispatch address goes out the same cycle.
    task automatic applyStimulus(input logic [4:0] idx, input logic [7:0] data);
        validCount = 0;
        doneCount  = 0;
        pushExpected({3'b000, idx}, data);
        @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_addr = idx; cpu_data = data;
        @(negedge clk);
        checkOutput("dispatch_rom_addr", {24'h0, rom_addr}, {24'h0, 3'b000, idx});
        checkOutput("dispatch_rom_cs", {31'h0, rom_cs}, 32'h1);
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic driveWrite(input logic [4:0] idx, input logic [7:0] data);
        @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_addr = idx; cpu_data = data;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n >= maxCycles) begin
                checkOutput("wait_idle_bound", {31'h0, busy}, 32'h0);
                break;
            end
        end
    endtask

    task automatic finishProgram();
        waitIdle(100);
        checkOutput("queue_drained", expQ.size(), 32'h0);
        checkOutput("done_count", doneCount, expTimeout ? 32'h0 : 32'h1);
        checkOutput("timeout_flag", {31'h0, timeout}, {31'h0, expTimeout});
    endtask

    // Scoreboard consumer: every issued word must match the next queued word.
    always @(negedge clk) begin
        if (monEn) begin
            if (uop_valid) begin
                validCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_uop", {8'h0, uop}, 32'h0);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("uop", {8'h0, uop}, {8'h0, monEntry.word});
                    checkOutput("uop_data", {24'h0, uop_data}, {24'h0, monEntry.data});
                    checkOutput("done_on_word", {31'h0, done}, {31'h0, monEntry.stop});
                    if (monEntry.stop) begin
                        checkOutput("rom_cs_after_stop", {31'h0, rom_cs}, 32'h0);
                    end else begin
                        checkOutput("rom_addr_next", {24'h0, rom_addr}, {24'h0, monEntry.nextAddr});
                        checkOutput("rom_cs_exec", {31'h0, rom_cs}, 32'h1);
                    end
                end
            end else if (done) begin
                checkOutput("spurious_done", {31'h0, done}, 32'h0);
            end
            if (done) doneCount++;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'hEE, 8'(i), 8'h10};
        // Dispatch: single STOP word
        rom[8'h10] = 24'h0B3B10;
        // Sequential with wrap: jump to 0xFE, run FE, FF, stop at 00
        rom[8'h01] = mkWord(8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        rom[8'hFE] = {8'h00, 8'hFE, 8'h00};
        rom[8'hFF] = {8'h00, 8'hFF, 8'h00};
        rom[8'h00] = mkWord(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        // Branches: not taken, taken, unconditional
        rom[8'h02] = mkWord(8'h4C, 1'b1, 1'b1, 1'b0, 1'b0);
        rom[8'h03] = mkWord(8'h4C, 1'b1, 1'b1, 1'b0, 1'b1);
        rom[8'h4C] = mkWord(8'h60, 1'b1, 1'b0, 1'b0, 1'b0);
        rom[8'h60] = mkWord(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        // STOP together with JMP: STOP must win
        rom[8'h04] = mkWord(8'h30, 1'b1, 1'b0, 1'b1, 1'b0);
        // Runaway self-jump
        rom[8'h05] = mkWord(8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        // Four-word program for the busy write
        rom[8'h08] = {8'h00, 8'h08, 8'h00};
        rom[8'h09] = {8'h00, 8'h09, 8'h00};
        rom[8'h0A] = {8'h00, 8'h0A, 8'h00};
        rom[8'h0B] = mkWord(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        reset = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_flags", {29'h0, overrun, timeout, done}, 32'h0);
        checkOutput("reset_uop_valid", {31'h0, uop_valid}, 32'h0);
        checkOutput("reset_rom", {23'h0, rom_cs, rom_addr}, 32'h0);
        checkOutput("reset_uop_data", {24'h0, uop_data}, 32'h0);
        monEn = 1'b1;

        // Dispatch latency: valid and done exactly two cycles after the write
        applyStimulus(5'h10, 8'h3C);
        @(negedge clk);
        checkOutput("t1_uop_valid", {31'h0, uop_valid}, 32'h0);
        checkOutput("t1_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        checkOutput("t2_uop_valid", {31'h0, uop_valid}, 32'h1);
        checkOutput("t2_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        checkOutput("t3_busy", {31'h0, busy}, 32'h0);
        checkOutput("t3_done_count", doneCount, 32'h1);
        checkOutput("t3_valid_count", validCount, 32'h1);

        applyStimulus(5'h01, 8'h21);
        finishProgram();
        applyStimulus(5'h02, 8'h42);
        finishProgram();
        applyStimulus(5'h04, 8'h44);
        finishProgram();

        // Write while busy is ignored and flagged
        applyStimulus(5'h08, 8'hA5);
        driveWrite(5'h10, 8'hEE);
        @(negedge clk);
        checkOutput("overrun_set", {31'h0, overrun}, 32'h1);
        finishProgram();
        checkOutput("overrun_sticky", {31'h0, overrun}, 32'h1);
        applyStimulus(5'h10, 8'h3C);
        @(negedge clk);
        checkOutput("overrun_cleared", {31'h0, overrun}, 32'h0);
        finishProgram();

        // Write in the STOP cycle still counts as busy
        applyStimulus(5'h10, 8'h3D);
        @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_addr = 5'h08; cpu_data = 8'h99;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        @(negedge clk);
        checkOutput("stop_cycle_busy", {31'h0, busy}, 32'h0);
        checkOutput("stop_cycle_overrun", {31'h0, overrun}, 32'h1);
        checkOutput("stop_cycle_done_count", doneCount, 32'h1);

        // Runaway program aborts after MAX_STEPS words
        applyStimulus(5'h05, 8'h55);
        finishProgram();
        checkOutput("runaway_valid_count", validCount, MAX_STEPS);

        // Reset mid-program
        applyStimulus(5'h05, 8'h77);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        monEn = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
        checkOutput("midreset_flags", {29'h0, overrun, timeout, done}, 32'h0);
        checkOutput("midreset_uop_valid", {31'h0, uop_valid}, 32'h0);
        checkOutput("midreset_rom", {23'h0, rom_cs, rom_addr}, 32'h0);
        checkOutput("midreset_uop_data", {24'h0, uop_data}, 32'h0);
        monEn = 1'b1;
        applyStimulus(5'h02, 8'h13);
        finishProgram();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
